sum_reg_adder: RTL and testbench

- Parameterised unsigned binary adder: two WIDTH-bit operands in, WIDTH-bit sum plus carry-out out.
- Datapath is a ripple-carry chain of full-adder cells.
- Results are registered, with a one-cycle valid pipeline.
- Used as a generic arithmetic leaf block wherever a registered N-bit add with carry is needed.

---
 rtl/sum_reg_adder_pkg.sv | 18 +
 rtl/sum_full_adder.sv | 18 +
 rtl/sum_reg_adder.sv | 80 ++++++++
 tb/tb_sum_reg_adder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sum_reg_adder_pkg.sv
`default_nettype none
// ============================================================================
// sum_reg_adder_pkg : shared widths and result type for sum_reg_adder
// Rev 1.0
// ============================================================================
package sum_reg_adder_pkg;

  localparam int SUM_DEFAULT_WIDTH = 4;
  localparam int SUM_MAX_WIDTH     = 64;

  // Sized for the widest legal adder; narrower users look at the low bits.
  typedef struct packed {
    logic                     c_out;
    logic [SUM_MAX_WIDTH-1:0] sum;
  } sum_result_t;

endpackage : sum_reg_adder_pkg
`default_nettype wire

// File: rtl/sum_full_adder.sv
`default_nettype none
// ============================================================================
// sum_full_adder : one-bit full-adder cell of the ripple chain
// Rev 1.0
// ============================================================================
module sum_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule : sum_full_adder
`default_nettype wire

// File: rtl/sum_reg_adder.sv
`default_nettype none
// ============================================================================
// sum_reg_adder : registered ripple-carry adder with carry-out and overflow
// Optional carry input: define SUM_REG_ADDER_CARRY_IN_EN. Rev 1.0
// ============================================================================
module sum_reg_adder
  import sum_reg_adder_pkg::*;
#(
  parameter int WIDTH = SUM_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
`ifdef SUM_REG_ADDER_CARRY_IN_EN
  input  logic             c_in,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > SUM_MAX_WIDTH) begin : g_width_check
    $error("sum_reg_adder: WIDTH out of range");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;

`ifdef SUM_REG_ADDER_CARRY_IN_EN
  assign carry[0] = c_in;
`else
  assign carry[0] = 1'b0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    sum_full_adder u_fa (
      .a  (data_a[i]),
      .b  (data_b[i]),
      .ci (carry[i]),
      .s  (sum_d[i]),
      .co (carry[i+1])
    );
  end

  // Carry into the MSB differs from carry out of it exactly on signed overflow.
  assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

  // Result registers only load on valid so idle (possibly X) operands never reach them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        c_out_q <= carry[WIDTH];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule : sum_reg_adder
`default_nettype wire

// File: tb/tb_sum_reg_adder.sv
`default_nettype none
// ============================================================================
// tb_sum_reg_adder : directed vectors, scoreboard queue checked by a monitor
// Rev 1.0
// ============================================================================
module tb_sum_reg_adder;
  import sum_reg_adder_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
`ifdef SUM_REG_ADDER_CARRY_IN_EN
  logic         c_in;
`endif
  logic         out_valid;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  typedef struct {
    sum_result_t res;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  sum_reg_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data_a    (data_a),
    .data_b    (data_b),
`ifdef SUM_REG_ADDER_CARRY_IN_EN
    .c_in      (c_in),
`endif
    .out_valid (out_valid),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operand pair at a negedge and queue its hand-computed result.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic ec, input logic [W-1:0] es, input logic eo);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    data_a   = a;
    data_b   = b;
`ifdef SUM_REG_ADDER_CARRY_IN_EN
    c_in     = ci;
`else
    if (ci) $display("note: carry-in ignored in this build");
`endif
    e.res       = '0;
    e.res.c_out = ec;
    e.res.sum[W-1:0] = es;
    e.ovf       = eo;
    q.push_back(e);
  endtask

  task automatic idle(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b0;
    data_a   = a;
    data_b   = b;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [W-1:0] s,
                            input logic c, input logic o);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".sum"},       64'(sum),       64'(s));
    check({tag, ".c_out"},     64'(c_out),     64'(c));
    check({tag, ".ovf"},       64'(ovf),       64'(o));
  endtask

  // Monitor: every presented result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_result: got out_valid=1 sum=%0h expected no result", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", {59'd0, c_out, sum, ovf}, {59'd0, e.res.c_out, e.res.sum[W-1:0], e.ovf});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_a   = 4'b0011;
    data_b   = 4'b0101;
`ifdef SUM_REG_ADDER_CARRY_IN_EN
    c_in     = 1'b0;
`endif
    // Reset held with valid operands: nothing may be captured.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs("reset", 1'b0, 4'b0000, 1'b0, 1'b0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;

    drive(4'b0011, 4'b0101, 1'b0, 1'b0, 4'b1000, 1'b1);
    drive(4'b1111, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0);
    drive(4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1110, 1'b0);
    idle(4'b0000, 4'b0000);

    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    drive(4'b0001, 4'b0010, 1'b0, 1'b0, 4'b0011, 1'b0);
    drive(4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b1);
    drive(4'b1000, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b1);
    drive(4'b1010, 4'b0101, 1'b0, 1'b0, 4'b1111, 1'b0);

    // Hold: new and then unknown operands with valid low must not disturb results.
    idle(4'b1111, 4'b1111);
    @(negedge clk);
    check_outs("hold", 1'b0, 4'b1111, 1'b0, 1'b0);
    data_a = 'x;
    data_b = 'x;
    @(negedge clk);
    check_outs("hold_x", 1'b0, 4'b1111, 1'b0, 1'b0);

    // Mid-stream reset: the operand presented with reset is discarded.
    drive(4'b0110, 4'b0011, 1'b0, 1'b0, 4'b1001, 1'b1);
    @(negedge clk);
    rst_n    = 1'b0;
    data_a   = 4'b1111;
    data_b   = 4'b1111;
    @(negedge clk);
    check_outs("mid_reset", 1'b0, 4'b0000, 1'b0, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    drive(4'b0100, 4'b0100, 1'b0, 1'b0, 4'b1000, 1'b1);

`ifdef SUM_REG_ADDER_CARRY_IN_EN
    drive(4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0);
    drive(4'b0111, 4'b1000, 1'b1, 1'b1, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_outs("cin_reset", 1'b0, 4'b0000, 1'b0, 1'b0);
    rst_n    = 1'b1;
`endif

    idle(4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    check("pending_results", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sum_reg_adder
`default_nettype wire
